uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one multi-byte UART frame transmitter (start pulse, BYTE_NUM*8-bit frame, busy/finish status) among NUM_REQ requesters.
- Arbitration is round-robin.
- Each granted frame is captured, launched with a one-cycle start pulse, and supervised until finish or timeout. The owner then gets a done or error pulse.
- Sits between the producer blocks (status reporters, debug dumpers) and the UART frame transmitter. It is the only driver of the transmitter's start and data inputs.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
BYTE_NUM, 9, bytes per frame; must match transmitter
TIMEOUT_CYC, 0, max cycles in WAIT before abort; 0 disables the timeout
ID_W, derived localparam = ceil(log2(NUM_REQ)), grant index width

Ports:
CLK_I  in  1  system clock
RST_I  in  1  reset, asynchronous, active-high
REQ_I  in  NUM_REQ  level request per requester; hold until ACK_O[i]
DATA_I  in  NUM_REQ*BYTE_NUM*8  frame of requester i at bits [(i+1)*BYTE_NUM*8-1 : i*BYTE_NUM*8]
ACK_O  out  NUM_REQ  one-cycle pulse: request i granted, frame captured
DONE_O  out  NUM_REQ  one-cycle pulse: frame of i finished
ERR_O  out  NUM_REQ  one-cycle pulse: frame of i timed out
GNT_ID_O  out  ID_W  index of current/last owner
BUSY_O  out  1  arbiter not in IDLE
TX_START_O  out  1  start pulse to transmitter
TX_DATA_O  out  BYTE_NUM*8  registered frame to transmitter, MSB byte sent first
TX_BUSY_I  in  1  transmitter busy (may rise combinationally with TX_START_O)
TX_FINISH_I  in  1  transmitter finish pulse/level

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, last_grant = NUM_REQ-1 (requester 0 wins first).
- Reset is asynchronous and takes effect mid-frame. The transmitter shares RST_I.
- State machine states are IDLE, WAIT and DRAIN. Every output is registered.

IDLE:
- Arbitrates when |REQ_I and TX_BUSY_I==0.
- Winner g is the first set REQ_I bit, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
- On the winning edge, register: ACK_O[g]=1, TX_START_O=1, TX_DATA_O=slice g, GNT_ID_O=g, BUSY_O=1, counter=0. Next state is WAIT.
- If TX_BUSY_I==1, no grant is made and requests wait.
- Latency: REQ sampled at edge N gives ACK_O/TX_START_O high in cycle N..N+1, exactly one cycle.

WAIT:
- ACK_O and TX_START_O return to 0. The counter increments each cycle.
- If TX_FINISH_I==1: DONE_O[g]=1 for one cycle, last_grant=g, next state DRAIN.
- Else if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1: ERR_O[g]=1 for one cycle, last_grant=g, next state DRAIN.
- If finish and timeout occur in the same cycle, finish wins: DONE only, no ERR.

DRAIN:
- Waits for TX_BUSY_I==0 and TX_FINISH_I==0, then goes to IDLE with BUSY_O=0.
- This prevents relaunch while a stretched finish or busy tail is still active.

General rules:
- Requests are sampled only in IDLE. A request dropped before ACK is forgotten.
- A REQ_I still high after ACK is a new request. It competes again next IDLE, behind the other requesters.
- DATA_I of the owner may change after ACK; TX_DATA_O is held until the next grant.
- At most one bit of ACK_O, DONE_O and ERR_O is set at any time. DONE and ERR are never both pulsed for the same grant.
- Minimum spacing between two TX_START_O pulses is 3 cycles.

Test Plan:
- Single request: REQ_I=4'b0001, slice0=72'h010203040506070809, TX idle → next cycle ACK_O=0001, TX_START_O=1, TX_DATA_O=72'h01..09. Model finish 100 cycles later → DONE_O=0001 for one cycle; BUSY_O=0 once TX_BUSY_I=0.
- Round-robin: REQ_I=4'b1111, each requester re-raises after its ACK → grant order 0,1,2,3,0,1. TX_START_O pulses are never closer than 3 cycles.
- Wrap-around: last_grant=3, REQ_I=4'b0101 → grant 0, then grant 2. With last_grant=2 and the same request → grant 0 first.
- Timeout: TIMEOUT_CYC=50, model holds busy and never finishes → ERR_O[g] pulses exactly 50 cycles after TX_START_O, no DONE. Arbiter stays in DRAIN until busy drops, then grants the next request.
- Simultaneous finish and timeout: TX_FINISH_I rises on the timeout cycle → DONE_O pulses, ERR_O stays 0.
- Blocked start and reset: TX_BUSY_I=1 in IDLE with REQ_I=4'b0010 → no ACK until busy falls. Assert RST_I mid-WAIT → all outputs 0 immediately without waiting for a clock edge; first post-reset grant is the lowest-index requester.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one multi-byte UART frame transmitter among NUM_REQ requesters.
// Captures the winner's frame, pulses start, then supervises until finish or timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned BYTE_NUM    = 9,
    parameter int unsigned TIMEOUT_CYC = 0,
    localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                           CLK_I,
    input  logic                           RST_I,
    input  logic [NUM_REQ-1:0]             REQ_I,
    input  logic [NUM_REQ*BYTE_NUM*8-1:0]  DATA_I,
    output logic [NUM_REQ-1:0]             ACK_O,
    output logic [NUM_REQ-1:0]             DONE_O,
    output logic [NUM_REQ-1:0]             ERR_O,
    output logic [ID_W-1:0]                GNT_ID_O,
    output logic                           BUSY_O,
    output logic                           TX_START_O,
    output logic [BYTE_NUM*8-1:0]          TX_DATA_O,
    input  logic                           TX_BUSY_I,
    input  logic                           TX_FINISH_I
);

    localparam int unsigned FW = BYTE_NUM * 8;
    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic [ID_W-1:0]      gnt_q, gnt_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic [FW-1:0]        data_q, data_d;

    logic                 win_vld;
    logic [ID_W-1:0]      win_id;
    logic [ID_W-1:0]      scan_id;

    // Search starts just above the last finished owner so it drops to lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        scan_id = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            scan_id = ID_W'((32'(last_q) + off) % NUM_REQ);
            if (!win_vld && REQ_I[scan_id]) begin
                win_vld = 1'b1;
                win_id  = scan_id;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = '0;
        start_d = 1'b0;
        gnt_d   = gnt_q;
        data_d  = data_q;

        unique case (state_q)
            StIdle: begin
                if (win_vld && !TX_BUSY_I) begin
                    ack_d   = NUM_REQ'(1) << win_id;
                    start_d = 1'b1;
                    gnt_d   = win_id;
                    data_d  = DATA_I[32'(win_id)*FW +: FW];
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CW'(1);
                // Finish is checked first so a coincident timeout never reports an error.
                if (TX_FINISH_I) begin
                    done_d  = NUM_REQ'(1) << gnt_q;
                    last_d  = gnt_q;
                    state_d = StDrain;
                end else if (TIMEOUT_CYC != 0 && cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    err_d   = NUM_REQ'(1) << gnt_q;
                    last_d  = gnt_q;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!TX_BUSY_I && !TX_FINISH_I) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= StIdle;
            last_q  <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            data_q  <= data_d;
        end
    end

    assign ACK_O      = ack_q;
    assign DONE_O     = done_q;
    assign ERR_O      = err_q;
    assign GNT_ID_O   = gnt_q;
    assign BUSY_O     = busy_q;
    assign TX_START_O = start_q;
    assign TX_DATA_O  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed and randomized frames checked against a round-robin
// model; a second instance with the timeout disabled covers the long-frame case.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int BN = 9;
    localparam int FW = BN * 8;
    localparam int TO = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req;
    logic [FW-1:0]    slice [NR];
    logic [NR*FW-1:0] data;
    logic             tx_busy, tx_fin;
    logic [NR-1:0]    ack, done, err;
    logic [1:0]       gnt;
    logic             busy_o, start;
    logic [FW-1:0]    txd;

    logic [NR-1:0]    nt_req;
    logic             nt_busy, nt_fin;
    logic [NR-1:0]    nt_ack, nt_done, nt_err;
    logic [1:0]       nt_gnt;
    logic             nt_busy_o, nt_start;
    logic [FW-1:0]    nt_txd;

    assign data = {slice[3], slice[2], slice[1], slice[0]};

    uart_tx_arbiter #(.NUM_REQ(NR), .BYTE_NUM(BN), .TIMEOUT_CYC(TO)) u_dut (
        .CLK_I(clk), .RST_I(rst), .REQ_I(req), .DATA_I(data),
        .ACK_O(ack), .DONE_O(done), .ERR_O(err), .GNT_ID_O(gnt), .BUSY_O(busy_o),
        .TX_START_O(start), .TX_DATA_O(txd), .TX_BUSY_I(tx_busy), .TX_FINISH_I(tx_fin)
    );

    uart_tx_arbiter #(.NUM_REQ(NR), .BYTE_NUM(BN), .TIMEOUT_CYC(0)) u_dut_nt (
        .CLK_I(clk), .RST_I(rst), .REQ_I(nt_req), .DATA_I(data),
        .ACK_O(nt_ack), .DONE_O(nt_done), .ERR_O(nt_err), .GNT_ID_O(nt_gnt),
        .BUSY_O(nt_busy_o), .TX_START_O(nt_start), .TX_DATA_O(nt_txd),
        .TX_BUSY_I(nt_busy), .TX_FINISH_I(nt_fin)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int model_last = NR - 1;
    int last_start = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference rule: first requester set, scanning upward from last owner + 1 with wrap.
    function automatic int rr_pick(input int last, input logic [NR-1:0] r);
        for (int off = 1; off <= NR; off++) begin
            if (r[(last + off) % NR]) return (last + off) % NR;
        end
        return -1;
    endfunction

    // One grant: fin_lat = edge after start at which finish is sampled (0 = never);
    // drain = extra cycles of busy (error) or stretched finish (done) before release.
    task automatic run_frame(input logic [NR-1:0] r, input int fin_lat, input int drain,
                             input bit clr);
        int g, ev, k;
        bit is_done;
        logic [NR-1:0] oh;
        logic [FW-1:0] exp_data;
        g = rr_pick(model_last, r);
        oh = 4'b0001 << g;
        exp_data = slice[g];
        req = r;
        k = 0;
        do begin
            step;
            k++;
        end while (ack == '0 && k < 20);
        check("ack", ack, oh);
        check("start", start, 1);
        check("gnt_id", gnt, g);
        check("busy_on_grant", busy_o, 1);
        check("tx_data", txd, exp_data);
        if (last_start >= 0) check("start_gap_ge3", (cyc - last_start) >= 3, 1);
        last_start = cyc;
        if (clr) req[g] = 1'b0;
        slice[g] = 72'({$urandom(), $urandom(), $urandom()});
        tx_busy = 1'b1;
        is_done = (fin_lat >= 1 && fin_lat <= TO);
        ev = is_done ? fin_lat : TO;
        for (int i = 1; i <= ev; i++) begin
            tx_fin = (i == fin_lat);
            step;
            check("done", done, (i == ev && is_done) ? oh : 4'b0);
            check("err", err, (i == ev && !is_done) ? oh : 4'b0);
            check("quiet_ack_start", {ack, start}, 0);
        end
        tx_busy = !is_done;
        tx_fin  = is_done;
        for (int i = 0; i < drain; i++) begin
            step;
            check("drain_busy", busy_o, 1);
            check("drain_quiet", {ack, start, done, err}, 0);
        end
        tx_busy = 1'b0;
        tx_fin  = 1'b0;
        step;
        check("idle_busy", busy_o, 0);
        check("data_held", txd, exp_data);
        model_last = g;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, k;
        req = '0;
        tx_busy = 1'b0;
        tx_fin = 1'b0;
        nt_req = '0;
        nt_busy = 1'b0;
        nt_fin = 1'b0;
        for (int i = 0; i < NR; i++) slice[i] = 72'({$urandom(), $urandom(), $urandom()});
        #2;
        check("reset_outputs", {ack, done, err, gnt, busy_o, start}, 0);
        check("reset_txdata", txd, 0);
        step;
        step;
        rst = 1'b0;

        // Long frame on the instance without timeout.
        slice[0] = 72'h010203040506070809;
        nt_req = 4'b0001;
        step;
        check("nt_ack", nt_ack, 4'b0001);
        check("nt_start", nt_start, 1);
        check("nt_data", nt_txd, 72'h010203040506070809);
        nt_req = '0;
        nt_busy = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            nt_fin = (i == 100);
            step;
            check("nt_done", nt_done, (i == 100) ? 4'b0001 : 4'b0);
            check("nt_err", nt_err, 0);
        end
        nt_fin = 1'b0;
        step;
        check("nt_busy_tail", nt_busy_o, 1);
        nt_busy = 1'b0;
        step;
        check("nt_idle", nt_busy_o, 0);

        // Round-robin with all requesters held: 0,1,2,3,0,1 at minimum spacing.
        for (int i = 0; i < 6; i++) run_frame(4'b1111, (i % 2 == 0) ? 1 : 3, 0, 1'b0);
        check("rr_last", model_last, 1);

        // Wrap-around from last owner 3, then from last owner 2.
        run_frame(4'b1000, 5, 1, 1'b1);
        run_frame(4'b0101, 4, 0, 1'b0);
        run_frame(4'b0101, 4, 0, 1'b0);
        check("wrap_last2", model_last, 2);
        run_frame(4'b0101, 2, 0, 1'b1);

        // Single request with the known frame.
        slice[0] = 72'h010203040506070809;
        run_frame(4'b0001, 30, 1, 1'b1);

        // Timeout with a busy tail, then finish coincident with timeout.
        run_frame(4'b0010, 0, 5, 1'b1);
        run_frame(4'b0100, TO, 0, 1'b1);

        // Transmitter busy blocks the grant.
        tx_busy = 1'b1;
        req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step;
            check("blocked_ack", {ack, start}, 0);
        end
        tx_busy = 1'b0;
        run_frame(4'b0010, 3, 0, 1'b1);

        // Asynchronous reset in the middle of WAIT.
        req = 4'b0100;
        k = 0;
        do begin
            step;
            k++;
        end while (ack == '0 && k < 20);
        check("pre_reset_ack", ack, 4'b0100);
        req = '0;
        tx_busy = 1'b1;
        step;
        step;
        #3 rst = 1'b1;
        #1;
        check("async_reset_outputs", {ack, done, err, gnt, busy_o, start}, 0);
        check("async_reset_txdata", txd, 0);
        tx_busy = 1'b0;
        step;
        rst = 1'b0;
        model_last = NR - 1;
        last_start = -100;
        run_frame(4'b1111, 2, 0, 1'b1);
        check("post_reset_owner", model_last, 0);

        // Randomized frames against the model.
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(1, 15);
            run_frame(4'(r), $urandom_range(0, 60), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
